// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Owns the single shared pipelined main memory on behalf of the I-cache and D-cache.
//   Sequences 8-word block fills on a miss (back-to-back read issue, streamed fill into the
//   grantee's data array, then one metadata write pulse) and one-cycle write-through stores.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   icache_miss/_addr            I-cache miss request, held until its tag is written
//   dcache_miss/_addr            D-cache miss request, held until its tag is written
//   dcache_wr_req/_addr/_data    D-cache write-through store request
//   mem_enable/wr/addr/data_out  memory request (registered)
//   mem_data_valid/mem_data_in   memory read return, MEM_LATENCY cycles after issue
//   fill_addr/fill_data          word being written into a cache data array
//   icache_/dcache_fill_wen      data-array write enables (same cycle as read return)
//   icache_/dcache_tag_wen       one-cycle metadata write pulse at the end of a fill
//   icache_/dcache_stall         pipeline stalls (combinational)
//   wr_ack                       one-cycle pulse in the cycle a store is issued
module cache_mem_arbiter #(
  parameter int unsigned MEM_LATENCY     = 4,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  input  logic              dcache_wr_req,
  input  logic [ADDR_W-1:0] dcache_wr_addr,
  input  logic [15:0]       dcache_wr_data,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data_out,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_data_in,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [15:0]       fill_data,
  output logic              icache_fill_wen,
  output logic              dcache_fill_wen,
  output logic              icache_tag_wen,
  output logic              dcache_tag_wen,
  output logic              icache_stall,
  output logic              dcache_stall,
  output logic              wr_ack
);

  // Counters must hold 0..WORDS_PER_BLOCK; byte offset bits cover a whole block of 16-bit words.
  localparam int unsigned CntW = $clog2(WORDS_PER_BLOCK + 1);
  localparam int unsigned OffW = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [CntW-1:0] Words    = CntW'(WORDS_PER_BLOCK);
  localparam logic [CntW-1:0] LastWord = CntW'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StFill, StFinish} state_e;
  typedef enum logic [1:0] {GntNone, GntI, GntD} grant_e;

  state_e            state_q;
  grant_e            grant_q;
  grant_e            last_grant_q;
  logic [CntW-1:0]   issue_cnt_q;
  logic [CntW-1:0]   recv_cnt_q;
  logic [ADDR_W-1:0] base_q;

  logic              icache_pick;
  logic              miss_pick;
  grant_e            miss_grant;
  logic [ADDR_W-1:0] miss_base;
  logic              fill_beat;
  logic              busy;
  logic              unused_offset;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CntW-1:0] idx);
    return base + ADDR_W'({idx, 1'b0});
  endfunction

  // The I-cache miss jumps ahead of a pending store when the D side was served last,
  // so a stream of stores cannot starve instruction fetch. A D miss always wins.
  assign icache_pick = icache_miss && (!dcache_wr_req || (last_grant_q == GntD));
  assign miss_pick   = dcache_miss || icache_pick;
  assign miss_grant  = dcache_miss ? GntD : GntI;
  assign miss_base   = dcache_miss ? {dcache_miss_addr[ADDR_W-1:OffW], {OffW{1'b0}}}
                                   : {icache_miss_addr[ADDR_W-1:OffW], {OffW{1'b0}}};
  assign unused_offset = ^{icache_miss_addr[OffW-1:0], dcache_miss_addr[OffW-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      grant_q        <= GntNone;
      last_grant_q   <= GntD;
      issue_cnt_q    <= '0;
      recv_cnt_q     <= '0;
      base_q         <= '0;
      mem_enable     <= 1'b0;
      mem_wr         <= 1'b0;
      mem_addr       <= '0;
      mem_data_out   <= '0;
      wr_ack         <= 1'b0;
      icache_tag_wen <= 1'b0;
      dcache_tag_wen <= 1'b0;
    end else begin
      // Request and pulse outputs are zero unless a state drives them this cycle.
      mem_enable     <= 1'b0;
      mem_wr         <= 1'b0;
      mem_addr       <= '0;
      mem_data_out   <= '0;
      wr_ack         <= 1'b0;
      icache_tag_wen <= 1'b0;
      dcache_tag_wen <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (miss_pick) begin
            // Word 0 is issued straight out of the grant edge.
            state_q      <= StFill;
            grant_q      <= miss_grant;
            last_grant_q <= miss_grant;
            base_q       <= miss_base;
            mem_enable   <= 1'b1;
            mem_addr     <= miss_base;
            issue_cnt_q  <= CntW'(1);
          end else if (dcache_wr_req) begin
            state_q      <= StWrite;
            mem_enable   <= 1'b1;
            mem_wr       <= 1'b1;
            mem_addr     <= dcache_wr_addr;
            mem_data_out <= dcache_wr_data;
            wr_ack       <= 1'b1;
          end
        end

        StWrite: begin
          state_q <= StIdle;
        end

        StFill: begin
          if (issue_cnt_q < Words) begin
            mem_enable  <= 1'b1;
            mem_addr    <= word_addr(base_q, issue_cnt_q);
            issue_cnt_q <= issue_cnt_q + CntW'(1);
          end
          if (mem_data_valid) begin
            recv_cnt_q <= recv_cnt_q + CntW'(1);
            if (recv_cnt_q == LastWord) begin
              state_q        <= StFinish;
              icache_tag_wen <= (grant_q == GntI);
              dcache_tag_wen <= (grant_q == GntD);
            end
          end
        end

        StFinish: begin
          state_q     <= StIdle;
          grant_q     <= GntNone;
          issue_cnt_q <= '0;
          recv_cnt_q  <= '0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Returned words are written in the same cycle they arrive; returns outside FILL are dropped.
  assign fill_beat       = (state_q == StFill) && mem_data_valid;
  assign icache_fill_wen = fill_beat && (grant_q == GntI);
  assign dcache_fill_wen = fill_beat && (grant_q == GntD);
  assign fill_addr       = fill_beat ? word_addr(base_q, recv_cnt_q) : '0;
  assign fill_data       = fill_beat ? mem_data_in : '0;

  // Gated by rst so every output reads 0 while reset is held, even with a miss pending.
  assign busy         = (state_q != StIdle);
  assign icache_stall = rst & (icache_miss | (busy & (grant_q == GntI)));
  assign dcache_stall = rst & (dcache_miss | (dcache_wr_req & ~wr_ack) |
                               (busy & (grant_q == GntD)));

`ifndef SYNTHESIS
  // A read return during a fill must match a read issued MEM_LATENCY cycles earlier.
  a_return_latency : assert property (@(posedge clk) disable iff (!rst)
    (state_q == StFill && mem_data_valid) |-> $past(mem_enable && !mem_wr, MEM_LATENCY));
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int Lat = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_miss;
  logic [15:0] icache_miss_addr;
  logic        dcache_miss;
  logic [15:0] dcache_miss_addr;
  logic        dcache_wr_req;
  logic [15:0] dcache_wr_addr;
  logic [15:0] dcache_wr_data;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic [15:0] mem_data_in;
  logic [15:0] fill_addr;
  logic [15:0] fill_data;
  logic        icache_fill_wen;
  logic        dcache_fill_wen;
  logic        icache_tag_wen;
  logic        dcache_tag_wen;
  logic        icache_stall;
  logic        dcache_stall;
  logic        wr_ack;

  int vectors = 0;
  int errors  = 0;

  // Memory model: read issues travel down a Lat-deep pipe and come back as valid + data.
  logic        pipe_v [0:Lat];
  logic [15:0] pipe_a [0:Lat];
  logic        inject;

  cache_mem_arbiter #(
    .MEM_LATENCY    (Lat),
    .WORDS_PER_BLOCK(8),
    .ADDR_W         (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .icache_miss     (icache_miss),
    .icache_miss_addr(icache_miss_addr),
    .dcache_miss     (dcache_miss),
    .dcache_miss_addr(dcache_miss_addr),
    .dcache_wr_req   (dcache_wr_req),
    .dcache_wr_addr  (dcache_wr_addr),
    .dcache_wr_data  (dcache_wr_data),
    .mem_enable      (mem_enable),
    .mem_wr          (mem_wr),
    .mem_addr        (mem_addr),
    .mem_data_out    (mem_data_out),
    .mem_data_valid  (mem_data_valid),
    .mem_data_in     (mem_data_in),
    .fill_addr       (fill_addr),
    .fill_data       (fill_data),
    .icache_fill_wen (icache_fill_wen),
    .dcache_fill_wen (dcache_fill_wen),
    .icache_tag_wen  (icache_tag_wen),
    .dcache_tag_wen  (dcache_tag_wen),
    .icache_stall    (icache_stall),
    .dcache_stall    (dcache_stall),
    .wr_ack          (wr_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i <= Lat; i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = 16'h0000;
    end
    mem_data_valid = 1'b0;
    mem_data_in    = 16'h0000;
  endtask

  // Advance one cycle; outputs are then observed 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = Lat; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0]      = mem_enable && !mem_wr;
    pipe_a[0]      = mem_addr;
    mem_data_valid = pipe_v[Lat] | inject;
    mem_data_in    = pipe_v[Lat] ? (pipe_a[Lat] ^ 16'h5A3C) : 16'hDEAD;
    #1;
  endtask

  // Called in the IDLE cycle where the miss is presented (cycle 0). Issues land in cycles 1..8,
  // fill beats in 5..12, the tag pulse in 13. Returns in cycle 13 with the miss dropped.
  task automatic do_fill(input bit is_d, input logic [15:0] base, input int drop_at);
    logic        en_exp;
    logic        fill_exp;
    logic [15:0] ea;
    chk("c0_mem_enable", mem_enable, 0);
    chk("c0_grantee_stall", is_d ? dcache_stall : icache_stall, 1);
    for (int k = 1; k <= 13; k++) begin
      step();
      en_exp = (k <= 8);
      chk("fill_mem_enable", mem_enable, en_exp);
      if (en_exp) begin
        ea = base + 16'(2 * (k - 1));
        chk("fill_mem_wr", mem_wr, 0);
        chk("fill_mem_addr", mem_addr, ea);
      end
      fill_exp = (k >= 5) && (k <= 12);
      chk("icache_fill_wen", icache_fill_wen, fill_exp && !is_d);
      chk("dcache_fill_wen", dcache_fill_wen, fill_exp && is_d);
      if (fill_exp) begin
        ea = base + 16'(2 * (k - 5));
        chk("fill_addr", fill_addr, ea);
        chk("fill_data", fill_data, ea ^ 16'h5A3C);
      end
      chk("icache_tag_wen", icache_tag_wen, (k == 13) && !is_d);
      chk("dcache_tag_wen", dcache_tag_wen, (k == 13) && is_d);
      chk("fill_wr_ack", wr_ack, 0);
      chk("fill_icache_stall", icache_stall, icache_miss | !is_d);
      chk("fill_dcache_stall", dcache_stall, dcache_miss | dcache_wr_req | is_d);
      if (k == drop_at) begin
        if (is_d) dcache_miss = 1'b0;
        else      icache_miss = 1'b0;
      end
    end
    if (is_d) dcache_miss = 1'b0;
    else      icache_miss = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_enable"}, mem_enable, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_data_out"}, mem_data_out, 0);
    chk({tag, "_fill_addr"}, fill_addr, 0);
    chk({tag, "_fill_data"}, fill_data, 0);
    chk({tag, "_fill_wen"}, {icache_fill_wen, dcache_fill_wen}, 0);
    chk({tag, "_tag_wen"}, {icache_tag_wen, dcache_tag_wen}, 0);
    chk({tag, "_stalls"}, {icache_stall, dcache_stall}, 0);
    chk({tag, "_wr_ack"}, wr_ack, 0);
  endtask

  initial begin
    rst              = 1'b0;
    icache_miss      = 1'b0;
    icache_miss_addr = 16'h0000;
    dcache_miss      = 1'b0;
    dcache_miss_addr = 16'h0000;
    dcache_wr_req    = 1'b0;
    dcache_wr_addr   = 16'h0000;
    dcache_wr_data   = 16'h0000;
    inject           = 1'b0;
    clear_pipe();

    // Reset state
    #12;
    chk_all_zero("reset");
    rst = 1'b1;
    step();

    // 1. I-cache fill of block 0x1230
    icache_miss      = 1'b1;
    icache_miss_addr = 16'h1236;
    #1;
    do_fill(1'b0, 16'h1230, 0);

    // 2. Simultaneous misses: D first, I in the IDLE cycle after D's FINISH
    step();
    icache_miss      = 1'b1;
    icache_miss_addr = 16'h0040;
    dcache_miss      = 1'b1;
    dcache_miss_addr = 16'h8000;
    #1;
    do_fill(1'b1, 16'h8000, 0);
    step();
    do_fill(1'b0, 16'h0040, 0);

    // 3. Fairness: after a D fill, a pending I miss beats a pending store
    step();
    dcache_miss      = 1'b1;
    dcache_miss_addr = 16'h2468;
    #1;
    do_fill(1'b1, 16'h2460, 0);
    dcache_wr_req    = 1'b1;
    dcache_wr_addr   = 16'h0100;
    dcache_wr_data   = 16'hBEEF;
    icache_miss      = 1'b1;
    icache_miss_addr = 16'h3008;
    step();
    chk("fair_dcache_stall", dcache_stall, 1);
    do_fill(1'b0, 16'h3000, 0);
    step();
    chk("fair_idle_mem_enable", mem_enable, 0);
    chk("fair_idle_dcache_stall", dcache_stall, 1);
    step();
    chk("fair_wr_mem_enable", mem_enable, 1);
    chk("fair_wr_mem_wr", mem_wr, 1);
    chk("fair_wr_mem_addr", mem_addr, 16'h0100);
    chk("fair_wr_mem_data_out", mem_data_out, 16'hBEEF);
    chk("fair_wr_ack", wr_ack, 1);
    chk("fair_wr_dcache_stall", dcache_stall, 0);
    dcache_wr_req = 1'b0;
    step();
    chk("fair_post_mem_enable", mem_enable, 0);
    chk("fair_post_wr_ack", wr_ack, 0);

    // 4. Store only
    dcache_wr_req  = 1'b1;
    dcache_wr_addr = 16'h00A2;
    dcache_wr_data = 16'h1234;
    #1;
    chk("st_pre_dcache_stall", dcache_stall, 1);
    chk("st_pre_wr_ack", wr_ack, 0);
    step();
    chk("st_mem_enable", mem_enable, 1);
    chk("st_mem_wr", mem_wr, 1);
    chk("st_mem_addr", mem_addr, 16'h00A2);
    chk("st_mem_data_out", mem_data_out, 16'h1234);
    chk("st_wr_ack", wr_ack, 1);
    chk("st_dcache_stall", dcache_stall, 0);
    dcache_wr_req = 1'b0;
    step();
    chk("st_post_mem_enable", mem_enable, 0);
    chk("st_post_wr_ack", wr_ack, 0);
    chk("st_post_dcache_stall", dcache_stall, 0);

    // 5. Reset after 5 words of a D fill, then restart from base+0
    dcache_miss      = 1'b1;
    dcache_miss_addr = 16'h4567;
    #1;
    for (int k = 1; k <= 9; k++) step();
    chk("rst_pre_dcache_fill_wen", dcache_fill_wen, 1);
    chk("rst_pre_fill_addr", fill_addr, 16'h4568);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    clear_pipe();
    step();
    chk("midrst_dcache_tag_wen", dcache_tag_wen, 0);
    step();
    chk("midrst2_dcache_tag_wen", dcache_tag_wen, 0);
    chk("midrst2_mem_enable", mem_enable, 0);
    rst = 1'b1;
    #1;
    do_fill(1'b1, 16'h4560, 0);

    // 6. I miss dropped at the 3rd issue; stray return while IDLE is ignored
    step();
    icache_miss      = 1'b1;
    icache_miss_addr = 16'h0F0A;
    #1;
    do_fill(1'b0, 16'h0F00, 3);
    step();
    inject         = 1'b1;
    mem_data_valid = 1'b1;
    mem_data_in    = 16'hDEAD;
    #1;
    chk("stray_icache_fill_wen", icache_fill_wen, 0);
    chk("stray_dcache_fill_wen", dcache_fill_wen, 0);
    chk("stray_fill_data", fill_data, 0);
    inject = 1'b0;
    step();
    chk("stray_post_mem_enable", mem_enable, 0);
    chk("stray_post_icache_tag_wen", icache_tag_wen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sequences block fills and write-through stores between the I-cache, the D-cache and the single shared pipelined main memory.
- Each cache is a 2-way, 64-set array with 8 words per block.
- On a miss the block fetches the 8-word block, streams the words into the requesting cache's data array, then writes that cache's tag/metadata.
- Sits between the two cache instances and the memory model. It owns every memory transaction.

Parameters:
MEM_LATENCY, 4, cycles from a read issue to the matching mem_data_valid
WORDS_PER_BLOCK, 8, words per cache block; the block is 16 bytes
ADDR_W, 16, address width in bits

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
icache_miss  in  1  I-cache miss; held high until the tag is written
icache_miss_addr  in  16  I-cache miss address
dcache_miss  in  1  D-cache miss; held high until the tag is written
dcache_miss_addr  in  16  D-cache miss address
dcache_wr_req  in  1  store write-through request
dcache_wr_addr  in  16  store address
dcache_wr_data  in  16  store data
mem_enable  out  1  memory access strobe
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  16  memory address
mem_data_out  out  16  memory write data
mem_data_valid  in  1  read data valid
mem_data_in  in  16  read data
fill_addr  out  16  address of the word being filled
fill_data  out  16  data of the word being filled
icache_fill_wen  out  1  data-array write enable, I-cache
dcache_fill_wen  out  1  data-array write enable, D-cache
icache_tag_wen  out  1  metadata write pulse, I-cache
dcache_tag_wen  out  1  metadata write pulse, D-cache
icache_stall  out  1  stall the fetch stage
dcache_stall  out  1  stall the memory stage
wr_ack  out  1  one-cycle pulse when a store is issued

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; issue_cnt=0, recv_cnt=0, grant=NONE, last_grant=D.
  - All outputs 0. mem_addr, fill_addr and fill_data are 0.
  - Reset mid-fill aborts silently. No tag_wen is ever produced for a partial fill, so partially written words stay invalid.
- States: IDLE, WRITE, FILL, FINISH.
- IDLE arbitration, evaluated each cycle:
  - Priority: dcache_miss > dcache_wr_req > icache_miss.
  - Exception: if last_grant=D and icache_miss=1, the I-cache miss wins over dcache_wr_req. It never wins over dcache_miss.
  - A miss grant latches base = {miss_addr[15:4],4'b0} and the grantee, sets last_grant, then goes to FILL.
  - A store grant goes to WRITE.
- WRITE (1 cycle):
  - Drives mem_enable=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_data_out=dcache_wr_data, wr_ack=1.
  - Next state is IDLE.
- FILL:
  - While issue_cnt<8: mem_enable=1, mem_wr=0, mem_addr=base+2*issue_cnt, then issue_cnt++. Issue is back-to-back, one per cycle.
  - On each mem_data_valid: the grantee's fill_wen=1, fill_addr=base+2*recv_cnt, fill_data=mem_data_in, then recv_cnt++.
  - A mem_data_valid seen while in IDLE or WRITE is ignored.
  - When recv_cnt reaches 8 (the 8th valid received), go to FINISH.
  - Total fill time is 8+MEM_LATENCY cycles from the grant.
- FINISH (1 cycle):
  - The grantee's tag_wen=1. The cache updates metadata and LRU on this edge.
  - Clear the counters and grant. Next state is IDLE.
- The miss input may drop mid-fill. The fill always completes; there is no abort path.
- A new request is accepted in the IDLE cycle after FINISH at the earliest.
- Stalls (combinational):
  - icache_stall = icache_miss | (state!=IDLE & grant==I).
  - dcache_stall = dcache_miss | (dcache_wr_req & ~wr_ack) | (state!=IDLE & grant==D).
- Only one of icache_fill_wen / dcache_fill_wen may be high in any cycle; the same holds for the two tag_wen outputs.
- Width rules: addresses wrap modulo 2^16. base+14 never crosses a block boundary, because the low 4 bits of base are 0.

Test Plan:
1. I-cache fill
   - Stimulus: rst low then high; icache_miss=1, addr=0x1236.
   - Response: mem_addr steps 0x1230,0x1232,…,0x123E over 8 cycles. icache_fill_wen is high on 8 cycles starting 4 cycles after the first issue, with fill_addr matching. icache_tag_wen pulses once on cycle 13 after the grant.
2. Simultaneous misses
   - Stimulus: icache_miss=1 (0x0040) and dcache_miss=1 (0x8000) in the same cycle.
   - Response: the D fill (0x8000–0x800E) completes first. The I fill starts in the IDLE cycle after D's FINISH. icache_stall stays high throughout.
3. Fairness
   - Stimulus: a D-cache fill completes; then dcache_wr_req (0x0100, 0xBEEF) and icache_miss are both pending.
   - Response: the I fill is granted first, then the store. The store shows mem_wr=1, mem_addr=0x0100, mem_data_out=0xBEEF, wr_ack=1.
4. Store only
   - Stimulus: dcache_wr_req=1 (0x00A2, 0x1234), no misses.
   - Response: a one-cycle WRITE with mem_wr=1, then back to IDLE. dcache_stall is high only before wr_ack.
5. Reset mid-fill
   - Stimulus: assert rst=0 after 5 words of a D-cache fill.
   - Response: all outputs 0 immediately (async). No dcache_tag_wen. After release, a new miss restarts the fill from base+0.
6. Miss dropped mid-fill
   - Stimulus: deassert icache_miss at the 3rd issue.
   - Response: all 8 words are still filled and icache_tag_wen still pulses. A stray mem_data_valid while IDLE causes no fill_wen.
